// File: rtl/brq_tap_pkg.sv
// Shared types and constants for the Buraq result tap.
package brq_tap_pkg;

    localparam int TAP_REG_DEFAULT = 10;
    localparam int DROP_CNT_MAX    = 255;

    // One queued result: sequence index plus the captured register value.
    typedef struct packed {
        logic [15:0] idx;
        logic [31:0] data;
    } brq_tap_entry_t;

endpackage

// File: rtl/brq_sync_fifo.sv
// Single-clock FIFO with registered head output and full-with-pop pass-through.
module brq_sync_fifo
    import brq_tap_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     brq_clk,
    input  logic                     brq_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_p0;
    logic [AW-1:0]    rd_ptr_p0;
    logic [AW:0]      count_p0;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_p0 == '0);
    assign full    = (count_p0 == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr_p0];
    assign count = count_p0;

    always_ff @(posedge brq_clk) begin
        if (do_push) begin
            mem[wr_ptr_p0] <= wdata;
        end
    end

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_p0 <= count_p0 + 1'b1;
                2'b01:   count_p0 <= count_p0 - 1'b1;
                default: count_p0 <= count_p0;
            endcase
        end
    end

endmodule

// File: rtl/brq_result_tap.sv
// Snoops the register-file write port and streams every write to TAP_REG
// out through Reg_Out and a valid/ready FIFO with sequence indices.
module brq_result_tap
    import brq_tap_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int TAP_REG   = TAP_REG_DEFAULT,
    parameter int DEPTH     = 8,
    parameter int DEDUP     = 0,
    parameter int IdxWidth  = 16
) (
    input  logic                     brq_clk,
    input  logic                     brq_rst,
    input  logic                     rf_we,
    input  logic [4:0]               rf_waddr,
    input  logic [DataWidth-1:0]     rf_wdata,
    output logic [DataWidth-1:0]     Reg_Out,
    output logic                     res_valid,
    output logic [DataWidth-1:0]     res_data,
    output logic [IdxWidth-1:0]      res_idx,
    input  logic                     res_ready,
    output logic [$clog2(DEPTH):0]   res_count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam logic [4:0] TAP_ADDR = 5'(TAP_REG);
    localparam int         ENTRY_W  = IdxWidth + DataWidth;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'(DROP_CNT_MAX)) ? v : v + 8'd1;
    endfunction

    logic [DataWidth-1:0] reg_out_p1;
    logic [IdxWidth-1:0]  next_idx_p1;
    logic                 captured_p1;
    logic                 overflow_p1;
    logic [7:0]           drop_cnt_p1;

    logic                 addr_hit_p0;
    logic                 dedup_ok_p0;
    logic                 vld_p0;
    logic                 pop_p0;
    logic                 push_ok_p0;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;

    // Stage p0: capture decode on the write port
    assign addr_hit_p0 = rf_we && (rf_waddr == TAP_ADDR) && (rf_waddr != 5'd0);
    assign dedup_ok_p0 = (DEDUP == 0) || !captured_p1 || (rf_wdata != reg_out_p1);
    assign vld_p0      = addr_hit_p0 && dedup_ok_p0;
    assign pop_p0      = res_valid && res_ready;
    assign push_ok_p0  = !fifo_full || pop_p0;
    assign fifo_wdata  = {next_idx_p1, rf_wdata};

    brq_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .brq_clk (brq_clk),
        .brq_rst (brq_rst),
        .push    (vld_p0),
        .pop     (res_ready),
        .wdata   (fifo_wdata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (res_count)
    );

    // Stage p1: held value, index sequencing and drop accounting
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            reg_out_p1  <= '0;
            next_idx_p1 <= '0;
            captured_p1 <= 1'b0;
            overflow_p1 <= 1'b0;
            drop_cnt_p1 <= '0;
        end else if (vld_p0) begin
            reg_out_p1  <= rf_wdata;
            captured_p1 <= 1'b1;
            // Index advances even on a drop so consumers can see the gap.
            next_idx_p1 <= next_idx_p1 + 1'b1;
            if (!push_ok_p0) begin
                overflow_p1 <= 1'b1;
                drop_cnt_p1 <= sat_inc8(drop_cnt_p1);
            end
        end
    end

    assign Reg_Out   = reg_out_p1;
    assign res_valid = !fifo_empty;
    assign res_idx   = fifo_rdata[ENTRY_W-1:DataWidth];
    assign res_data  = fifo_rdata[DataWidth-1:0];
    assign overflow  = overflow_p1;
    assign drop_cnt  = drop_cnt_p1;

endmodule

// File: tb/tb_brq_result_tap.sv
// Directed bench for brq_result_tap; a second instance runs with DEDUP=1.
module tb_brq_result_tap;

    logic        brq_clk = 1'b0;
    logic        brq_rst = 1'b1;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = 5'd0;
    logic [31:0] rf_wdata = '0;
    logic        res_ready = 1'b0;

    logic [31:0] reg_out, res_data;
    logic        res_valid, overflow;
    logic [15:0] res_idx;
    logic [3:0]  res_count;
    logic [7:0]  drop_cnt;

    logic [31:0] dd_reg_out, dd_data;
    logic        dd_valid, dd_overflow;
    logic [15:0] dd_idx;
    logic [3:0]  dd_count;
    logic [7:0]  dd_drop;

    int checks = 0;
    int failures = 0;

    always #5 brq_clk = ~brq_clk;

    brq_result_tap #(.DEDUP(0)) dut (
        .brq_clk(brq_clk), .brq_rst(brq_rst), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .Reg_Out(reg_out), .res_valid(res_valid),
        .res_data(res_data), .res_idx(res_idx), .res_ready(res_ready),
        .res_count(res_count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    brq_result_tap #(.DEDUP(1)) dut_dd (
        .brq_clk(brq_clk), .brq_rst(brq_rst), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .Reg_Out(dd_reg_out), .res_valid(dd_valid),
        .res_data(dd_data), .res_idx(dd_idx), .res_ready(res_ready),
        .res_count(dd_count), .overflow(dd_overflow), .drop_cnt(dd_drop)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge brq_clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic we);
        rf_we = we; rf_waddr = a; rf_wdata = d;
        cyc();
        rf_we = 1'b0;
    endtask

    task automatic do_reset();
        brq_rst = 1'b1;
        cyc(); cyc();
        brq_rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_regout", reg_out, 0);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_idx", res_idx, 0);
        check("rst_count", res_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);

        // Back-to-back captures with consumer always ready
        res_ready = 1'b1;
        wr(5'd10, 32'd495, 1'b1);
        check("t1_regout0", reg_out, 495);
        check("t1_valid0", res_valid, 1);
        check("t1_data0", res_data, 495);
        check("t1_idx0", res_idx, 0);
        wr(5'd10, 32'd1168, 1'b1);
        check("t1_regout1", reg_out, 1168);
        check("t1_data1", res_data, 1168);
        check("t1_idx1", res_idx, 1);
        check("t1_count1", res_count, 1);
        wr(5'd10, 32'd565, 1'b1);
        check("t1_regout2", reg_out, 565);
        check("t1_data2", res_data, 565);
        check("t1_idx2", res_idx, 2);
        cyc();
        check("t1_drained", res_valid, 0);
        check("t1_ovf", overflow, 0);

        // Non-matching writes leave everything alone
        res_ready = 1'b0;
        wr(5'd11, 32'd922, 1'b1);
        check("t2_x11_regout", reg_out, 565);
        check("t2_x11_valid", res_valid, 0);
        wr(5'd0, 32'd922, 1'b1);
        check("t2_x0_regout", reg_out, 565);
        check("t2_x0_valid", res_valid, 0);
        wr(5'd10, 32'd922, 1'b0);
        check("t2_we0_regout", reg_out, 565);
        check("t2_we0_valid", res_valid, 0);
        wr(5'd10, 32'd777, 1'b1);
        check("t2_next_idx", res_idx, 3);
        check("t2_next_data", res_data, 777);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;

        // Overflow: 10 captures into 8 entries
        do_reset();
        for (int i = 1; i <= 10; i++) wr(5'd10, 32'(i), 1'b1);
        check("t3_count", res_count, 8);
        check("t3_ovf", overflow, 1);
        check("t3_drop", drop_cnt, 2);
        check("t3_regout", reg_out, 10);
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_valid%0d", i), res_valid, 1);
            check($sformatf("t3_data%0d", i), res_data, 64'(i + 1));
            check($sformatf("t3_idx%0d", i), res_idx, 64'(i));
            cyc();
        end
        res_ready = 1'b0;
        check("t3_empty", res_valid, 0);
        wr(5'd10, 32'd11, 1'b1);
        check("t3_gap_idx", res_idx, 10);

        // Full FIFO accepts a push when a pop happens on the same edge
        for (int i = 12; i <= 18; i++) wr(5'd10, 32'(i), 1'b1);
        check("t4_full", res_count, 8);
        res_ready = 1'b1;
        wr(5'd10, 32'd19, 1'b1);
        res_ready = 1'b0;
        check("t4_count", res_count, 8);
        check("t4_drop", drop_cnt, 2);
        check("t4_head_data", res_data, 12);
        check("t4_head_idx", res_idx, 11);

        // Dedup versus plain capture
        do_reset();
        wr(5'd10, 32'd945, 1'b1);
        wr(5'd10, 32'd945, 1'b1);
        wr(5'd10, 32'd831, 1'b1);
        check("t5_plain_count", res_count, 3);
        check("t5_dd_count", dd_count, 2);
        check("t5_dd_data0", dd_data, 945);
        check("t5_dd_idx0", dd_idx, 0);
        check("t5_dd_regout", dd_reg_out, 831);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("t5_dd_data1", dd_data, 831);
        check("t5_dd_idx1", dd_idx, 1);
        check("t5_plain_data1", res_data, 945);
        check("t5_plain_idx1", res_idx, 1);

        // Mid-stream reset with a concurrent capture and handshake
        do_reset();
        for (int i = 1; i <= 5; i++) wr(5'd10, 32'(i), 1'b1);
        check("t6_count", res_count, 5);
        brq_rst = 1'b1; res_ready = 1'b1;
        wr(5'd10, 32'd999, 1'b1);
        brq_rst = 1'b0; res_ready = 1'b0;
        check("t6_regout", reg_out, 0);
        check("t6_valid", res_valid, 0);
        check("t6_data", res_data, 0);
        check("t6_idx", res_idx, 0);
        check("t6_cnt", res_count, 0);
        check("t6_ovf", overflow, 0);
        check("t6_drop", drop_cnt, 0);
        wr(5'd10, 32'd578, 1'b1);
        check("t6_post_valid", res_valid, 1);
        check("t6_post_data", res_data, 578);
        check("t6_post_idx", res_idx, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
